// File: rtl/md_iter_sequencer.sv
// md_iter_sequencer: iteration sequencer for a molecular-dynamics step loop.
// Each iteration runs three phases in order: position broadcast, force compute
// and motion update. iter_count advances after each motion update, until it
// reaches the target that was captured at start.
// Optional feature: define MD_SEQ_TIMEOUT_EN to enable a per-phase watchdog
// that parks the block in ERR (seq_err=1) until abort or reset.
module md_iter_sequencer #(
  parameter int ITER_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] iter_target,
  input  logic [ITER_WIDTH-1:0] init_step,
  output logic                  pos_start,
  output logic                  frc_start,
  output logic                  mu_start,
  input  logic                  pos_done,
  input  logic                  frc_done,
  input  logic                  mu_done,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [2:0]            phase,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic                  seq_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POS   = 3'd1,
    S_FRC   = 3'd2,
    S_MU    = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic                  first_cycle;  // high during the first cycle of any state
  logic [ITER_WIDTH-1:0] target_q;
  logic                  load_run;
  logic                  incr_iter;
  logic                  timeout_hit;

`ifdef MD_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] phase_tmr;
  logic             in_phase;

  assign in_phase = (state == S_POS) || (state == S_FRC) || (state == S_MU);

  // Watchdog: counts cycles spent in the current phase, restarting on every entry.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      phase_tmr <= '0;
    end else if (state_nxt != state) begin
      phase_tmr <= '0;
    end else if (in_phase) begin
      phase_tmr <= phase_tmr + TMR_W'(1);
    end
  end

  // The last permitted cycle is number TIMEOUT_CYCLES, i.e. a count of TIMEOUT_CYCLES-1.
  assign timeout_hit = in_phase && (phase_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign seq_err     = (state == S_ERR);
`else
  assign timeout_hit = 1'b0;
  assign seq_err     = 1'b0;
`endif

  // State register, entry flag, iteration counter and captured target.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (ap_rst) begin
      state       <= S_IDLE;
      first_cycle <= 1'b0;
      iter_count  <= '0;
      target_q    <= '0;
    end else begin
      state       <= state_nxt;
      first_cycle <= (state_nxt != state);
      if (load_run) begin
        iter_count <= init_step;
        target_q   <= iter_target;
      end else if (incr_iter) begin
        iter_count <= iter_count + ITER_WIDTH'(1);  // wraps naturally at all-ones
      end
    end
  end

  // Next-state and phase-launch logic; abort overrides everything outside IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_nxt = state;
    load_run  = 1'b0;
    incr_iter = 1'b0;
    pos_start = 1'b0;
    frc_start = 1'b0;
    mu_start  = 1'b0;
    ap_done   = 1'b0;
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state_nxt = S_CHECK;
            load_run  = 1'b1;
          end
        end
        S_CHECK: begin
          state_nxt = (iter_count >= target_q) ? S_DONE : S_POS;
        end
        // Within a phase, done is ignored in the launch cycle.
        S_POS: begin
          pos_start = first_cycle;
          if (!first_cycle && pos_done) state_nxt = S_FRC;
          else if (timeout_hit)         state_nxt = S_ERR;
        end
        S_FRC: begin
          frc_start = first_cycle;
          if (!first_cycle && frc_done) state_nxt = S_MU;
          else if (timeout_hit)         state_nxt = S_ERR;
        end
        S_MU: begin
          mu_start = first_cycle;
          if (!first_cycle && mu_done) begin
            state_nxt = S_CHECK;
            incr_iter = 1'b1;
          end else if (timeout_hit) begin
            state_nxt = S_ERR;
          end
        end
        S_DONE: begin
          ap_done   = 1'b1;
          state_nxt = S_IDLE;
        end
        S_ERR:   state_nxt = S_ERR;  // only abort or reset leaves
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign phase   = state;
  assign ap_idle = (state == S_IDLE);

endmodule

// File: doc/md_iter_sequencer.md
MD_ITER_SEQUENCER -- requirements
Module: md_iter_sequencer

Interface
REQ-001 SHALL have parameter ITER_WIDTH, default 32: width of the iteration counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit per phase; used only under MD_SEQ_TIMEOUT_EN.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have ports ap_clk (in, 1): rising-edge clock for all state.
REQ-005 SHALL have ap_rst (in, 1): asynchronous active-high reset.
REQ-006 SHALL have ap_start (in, 1): run request; level sampled in IDLE.
REQ-007 SHALL have abort (in, 1): synchronous cancel of the current run.
REQ-008 SHALL have iter_target (in, ITER_WIDTH): final iteration index.
REQ-009 SHALL have init_step (in, ITER_WIDTH): starting iteration index.
REQ-010 SHALL have pos_start, frc_start, mu_start (out, 1 each): one-cycle phase launch pulses for position broadcast, force compute and motion update.
REQ-011 SHALL have pos_done, frc_done, mu_done (in, 1 each): phase completion pulses.
REQ-012 SHALL have iter_count (out, ITER_WIDTH): current iteration index.
REQ-013 SHALL have phase (out, 3): state encoding IDLE=0, POS=1, FRC=2, MU=3, CHECK=4, DONE=5, ERR=6.
REQ-014 SHALL have ap_idle (out, 1), ap_done (out, 1, one-cycle pulse) and seq_err (out, 1).

Function
REQ-015 SHALL, in IDLE with ap_start=1, latch iter_target, load iter_count with init_step, and move to CHECK.
REQ-016 SHALL, in CHECK, go to DONE if iter_count >= latched target (unsigned compare), else go to POS.
REQ-017 SHALL assert the phase's *_start for exactly the first cycle in POS, FRC and MU.
REQ-018 SHALL ignore *_done in the cycle *_start is asserted; SHALL honour it from the following cycle.
REQ-019 SHALL take transitions POS->FRC on pos_done, FRC->MU on frc_done, and MU->CHECK on mu_done, incrementing iter_count in the same cycle as mu_done.
REQ-020 SHALL ignore *_done inputs belonging to phases other than the current one.
REQ-021 SHALL, in DONE, assert ap_done for one cycle and return to IDLE; if ap_start is still high, a new run SHALL NOT begin until one full IDLE cycle has elapsed.
REQ-022 SHALL assert ap_idle combinationally when the state is IDLE.
REQ-023 SHALL, on abort in any state other than IDLE, go to IDLE next cycle with no ap_done and no *_start pulse; abort SHALL take priority over a simultaneous *_done.
REQ-024 SHALL, when iter_count reaches all-ones on increment, wrap to 0 and be handled by CHECK unchanged.
REQ-025 SHALL sample iter_target only at start; later changes SHALL NOT affect the active run.

Reset
REQ-026 SHALL, on ap_rst, immediately set state to IDLE, iter_count and the latched target to 0, all *_start, ap_done and seq_err to 0, and ap_idle to 1.
REQ-027 SHALL, after reset is released mid-run, not resume the run; a new ap_start is required.

Configuration
REQ-028 SHALL, with macro MD_SEQ_TIMEOUT_EN defined, count cycles spent in POS, FRC or MU, clearing the count on each phase entry.
REQ-029 SHALL, under MD_SEQ_TIMEOUT_EN, enter ERR when the count reaches TIMEOUT_CYCLES without the phase's done.
REQ-030 SHALL, in ERR, hold seq_err=1 and ap_idle=0 until abort or ap_rst; abort SHALL then return the block to IDLE and clear seq_err.
REQ-031 SHALL, without MD_SEQ_TIMEOUT_EN, tie seq_err to 0, never enter ERR, and remove the counter logic.

Verification
REQ-032 SHALL cover a normal run: init_step=0, iter_target=2, each done 3 cycles after its start -> pos/frc/mu pulse twice each, iter_count goes 0->1->2, one ap_done, then ap_idle=1.
REQ-033 SHALL cover a zero-iteration run: init_step=5, iter_target=5 -> no *_start pulses, ap_done exactly 2 cycles after ap_start is sampled.
REQ-034 SHALL cover a done on the same cycle as its start: pos_done asserted with pos_start -> ignored, state stays POS; pos_done one cycle later -> move to FRC.
REQ-035 SHALL cover abort together with frc_done in FRC -> IDLE next cycle, no mu_start, no ap_done.
REQ-036 SHALL cover reset mid-run: ap_rst pulsed in MU with iter_count=3 -> iter_count=0, phase=0, ap_idle=1 with no clock edge required.
REQ-037 SHALL cover timeout with MD_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: frc_done withheld -> seq_err=1 after 8 cycles in FRC; abort -> IDLE with seq_err=0.
